regfile_scoreboard: RTL and testbench

Parametrised integer register file for the pipelined RISC-V core, replacing the fixed 32×32 single-cycle register file. It provides two combinational read ports and one writeback port, with optional write-to-read bypass and a per-register pending-write scoreboard. The decode stage uses the scoreboard to detect RAW hazards against in-flight producers. Sits between decode (reads, issue) and writeback (write, clear).

---
 rtl/regfile_scoreboard.sv | 129 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised integer register file with two combinational
// read ports, one writeback port, optional same-cycle write-to-read bypass and a
// per-register pending-write scoreboard used by decode for RAW hazard detection.
// Register 0 is hardwired to zero and is never tracked as busy.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  input  logic            regWrite,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] Data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic            busy1,
  output logic            busy2,
  output logic [AW:0]     pending_cnt
);

  localparam int NREG = 2 ** AW;
  localparam int CW   = AW + 1;

  logic [XLEN-1:0] regs_r [NREG];
  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;

  logic set_s;
  logic clr_s;
  logic inc_s;
  logic dec_s;
  logic byp1_s;
  logic byp2_s;

  // Qualified scoreboard events; an issue is dropped while flushing and x0 is never tracked.
  always_comb begin
    set_s = issue_valid && (issue_rd != {AW{1'b0}}) && !flush;
    clr_s = regWrite && (rd != {AW{1'b0}});
    // The count only moves when a bit actually changes; set wins over a same-index clear.
    inc_s = set_s && !busy_r[issue_rd];
    dec_s = clr_s && busy_r[rd] && !(set_s && (issue_rd == rd));
    byp1_s = (BYPASS != 0) && regWrite && (rd == rs1);
    byp2_s = (BYPASS != 0) && regWrite && (rd == rs2);
  end

  // Next busy vector and pending count: flush wipes everything, otherwise clear then set.
  always_comb begin
    busy_nxt_s = busy_r;
    cnt_nxt_s  = cnt_r;
    if (flush) begin
      busy_nxt_s = {NREG{1'b0}};
      cnt_nxt_s  = {CW{1'b0}};
    end else begin
      if (clr_s) begin
        busy_nxt_s[rd] = 1'b0;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      if (set_s) begin
        busy_nxt_s[issue_rd] = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      cnt_nxt_s = cnt_r + CW'(inc_s) - CW'(dec_s);
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= {NREG{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  // Register array; writes to x0 are discarded so it always reads back as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (regWrite && (rd != {AW{1'b0}})) begin
      regs_r[rd] <= Data;
    end
  end

  // Read ports; forced to zero while in reset so a bypassed write cannot leak out.
  always_comb begin
    if (!reset) begin
      readData1 = {XLEN{1'b0}};
    end else if (rs1 == {AW{1'b0}}) begin
      readData1 = {XLEN{1'b0}};
    end else if (byp1_s) begin
      readData1 = Data;
    end else begin
      readData1 = regs_r[rs1];
    end
    if (!reset) begin
      readData2 = {XLEN{1'b0}};
    end else if (rs2 == {AW{1'b0}}) begin
      readData2 = {XLEN{1'b0}};
    end else if (byp2_s) begin
      readData2 = Data;
    end else begin
      readData2 = regs_r[rs2];
    end
  end

  // Hazard outputs: a same-cycle forwarded writeback already satisfies the consumer.
  always_comb begin
    busy1 = (rs1 != {AW{1'b0}}) && busy_r[rs1] && !byp1_s;
    busy2 = (rs2 != {AW{1'b0}}) && busy_r[rs2] && !byp2_s;
  end

  assign pending_cnt = cnt_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: two instances (bypass on / off) share
// the same stimulus; the driver queues expected values per cycle and a monitor
// compares them against the selected instance on the falling clock edge.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0, issue_rd = 5'd0;
  logic        regWrite = 1'b0, issue_valid = 1'b0, flush = 1'b0;
  logic [31:0] Data = 32'd0;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        b1_b, b2_b, b1_n, b2_n;
  logic [5:0]  cnt_b, cnt_n;

  int total = 0;
  int passed = 0;

  typedef struct {
    string       nm;
    bit          sel;   // 1 = bypass instance, 0 = no-bypass instance
    logic [4:0]  m;     // compare mask {rd1, rd2, b1, b2, cnt}
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
    logic [5:0]  ec;
  } exp_t;

  exp_t exp_q[$];

  regfile_scoreboard #(.XLEN(32), .AW(5), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .readData1(rd1_b), .readData2(rd2_b),
    .regWrite(regWrite), .rd(rd), .Data(Data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .busy1(b1_b), .busy2(b2_b), .pending_cnt(cnt_b)
  );

  regfile_scoreboard #(.XLEN(32), .AW(5), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .readData1(rd1_n), .readData2(rd2_n),
    .regWrite(regWrite), .rd(rd), .Data(Data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .busy1(b1_n), .busy2(b2_n), .pending_cnt(cnt_n)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string nm, input bit sel, input logic [4:0] m,
                          input logic [31:0] e1, input logic [31:0] e2,
                          input logic eb1, input logic eb2, input logic [5:0] ec);
    exp_t e;
    e.nm = nm; e.sel = sel; e.m = m; e.e1 = e1; e.e2 = e2;
    e.eb1 = eb1; e.eb2 = eb2; e.ec = ec;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
  endtask

  // Monitor: on every falling edge, check all expectations queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] a1, a2;
      logic ab1, ab2;
      logic [5:0] ac;
      e = exp_q.pop_front();
      a1  = e.sel ? rd1_b : rd1_n;
      a2  = e.sel ? rd2_b : rd2_n;
      ab1 = e.sel ? b1_b : b1_n;
      ab2 = e.sel ? b2_b : b2_n;
      ac  = e.sel ? cnt_b : cnt_n;
      if (e.m[4]) cmp(e.nm, "readData1", a1, e.e1);
      if (e.m[3]) cmp(e.nm, "readData2", a2, e.e2);
      if (e.m[2]) cmp(e.nm, "busy1", {31'd0, ab1}, {31'd0, e.eb1});
      if (e.m[1]) cmp(e.nm, "busy2", {31'd0, ab2}, {31'd0, e.eb2});
      if (e.m[0]) cmp(e.nm, "pending_cnt", {26'd0, ac}, {26'd0, e.ec});
    end
  end

  initial begin
    #1 reset = 1'b0;
    // Reset: bypassed write must not leak out while reset is low.
    rs1 = 5'd5; rs2 = 5'd31; regWrite = 1'b1; rd = 5'd5; Data = 32'h0000AAAA;
    for (int s = 0; s < 2; s++) begin
      cyc();
      push_exp("reset_b", 1'b1, 5'b11111, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
      push_exp("reset_n", 1'b0, 5'b11111, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
    end
    // Release and write x7.
    cyc();
    reset = 1'b1;
    regWrite = 1'b1; rd = 5'd7; Data = 32'hDEADBEEF; rs1 = 5'd7; rs2 = 5'd0;
    push_exp("wr7_byp", 1'b1, 5'b10000, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 6'd0);
    push_exp("wr7_nobyp", 1'b0, 5'b10000, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
    cyc();
    regWrite = 1'b0;
    push_exp("rd7_b", 1'b1, 5'b10000, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 6'd0);
    push_exp("rd7_n", 1'b0, 5'b10000, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 6'd0);
    // x0: writes and issues ignored.
    cyc();
    regWrite = 1'b1; rd = 5'd0; Data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
    push_exp("x0_same_b", 1'b1, 5'b10100, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
    cyc();
    regWrite = 1'b0; issue_valid = 1'b0;
    push_exp("x0_next_b", 1'b1, 5'b10101, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
    push_exp("x0_next_n", 1'b0, 5'b10101, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
    // Bypass: preload x3, then overwrite while reading.
    cyc();
    regWrite = 1'b1; rd = 5'd3; Data = 32'h00001111;
    cyc();
    Data = 32'h00001234; rs1 = 5'd3; rs2 = 5'd3;
    push_exp("byp_same_b", 1'b1, 5'b11000, 32'h00001234, 32'h00001234, 1'b0, 1'b0, 6'd0);
    push_exp("byp_same_n", 1'b0, 5'b11000, 32'h00001111, 32'h00001111, 1'b0, 1'b0, 6'd0);
    cyc();
    regWrite = 1'b0;
    push_exp("byp_next_n", 1'b0, 5'b11000, 32'h00001234, 32'h00001234, 1'b0, 1'b0, 6'd0);
    // Scoreboard life cycle on x10.
    cyc();
    issue_valid = 1'b1; issue_rd = 5'd10; rs1 = 5'd10; rs2 = 5'd0;
    push_exp("sb_issue", 1'b1, 5'b00101, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
    cyc();
    issue_valid = 1'b0;
    push_exp("sb_busy_b", 1'b1, 5'b00101, 32'd0, 32'd0, 1'b1, 1'b0, 6'd1);
    push_exp("sb_busy_n", 1'b0, 5'b00101, 32'd0, 32'd0, 1'b1, 1'b0, 6'd1);
    cyc();
    cyc();
    regWrite = 1'b1; rd = 5'd10; Data = 32'h00000055;
    push_exp("sb_wb_b", 1'b1, 5'b00101, 32'd0, 32'd0, 1'b0, 1'b0, 6'd1);
    push_exp("sb_wb_n", 1'b0, 5'b00101, 32'd0, 32'd0, 1'b1, 1'b0, 6'd1);
    cyc();
    regWrite = 1'b0;
    push_exp("sb_done_b", 1'b1, 5'b10101, 32'h00000055, 32'd0, 1'b0, 1'b0, 6'd0);
    push_exp("sb_done_n", 1'b0, 5'b10101, 32'h00000055, 32'd0, 1'b0, 1'b0, 6'd0);
    // Simultaneous set and clear on x10: set wins.
    cyc();
    issue_valid = 1'b1; issue_rd = 5'd10;
    cyc();
    regWrite = 1'b1; rd = 5'd10; Data = 32'h00000077;
    push_exp("sc_same_b", 1'b1, 5'b10101, 32'h00000077, 32'd0, 1'b0, 1'b0, 6'd1);
    push_exp("sc_same_n", 1'b0, 5'b10101, 32'h00000055, 32'd0, 1'b1, 1'b0, 6'd1);
    cyc();
    regWrite = 1'b0; issue_valid = 1'b0;
    push_exp("sc_next_b", 1'b1, 5'b10101, 32'h00000077, 32'd0, 1'b1, 1'b0, 6'd1);
    push_exp("sc_next_n", 1'b0, 5'b10101, 32'h00000077, 32'd0, 1'b1, 1'b0, 6'd1);
    // Fill the scoreboard: x1..x31 (x10 already busy).
    for (int i = 1; i < 32; i++) begin
      cyc();
      issue_valid = 1'b1; issue_rd = 5'(i);
    end
    cyc();
    issue_valid = 1'b0; rs1 = 5'd1; rs2 = 5'd31;
    push_exp("full_b", 1'b1, 5'b00111, 32'd0, 32'd0, 1'b1, 1'b1, 6'd31);
    push_exp("full_n", 1'b0, 5'b00111, 32'd0, 32'd0, 1'b1, 1'b1, 6'd31);
    // Flush with a concurrent issue (dropped) and a writeback (lands).
    cyc();
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd4;
    regWrite = 1'b1; rd = 5'd20; Data = 32'h00000ABC; rs1 = 5'd4; rs2 = 5'd20;
    push_exp("flush_same_b", 1'b1, 5'b01111, 32'd0, 32'h00000ABC, 1'b1, 1'b0, 6'd31);
    push_exp("flush_same_n", 1'b0, 5'b01111, 32'd0, 32'd0, 1'b1, 1'b1, 6'd31);
    cyc();
    flush = 1'b0; issue_valid = 1'b0; regWrite = 1'b0;
    push_exp("flush_next_b", 1'b1, 5'b01111, 32'd0, 32'h00000ABC, 1'b0, 1'b0, 6'd0);
    push_exp("flush_next_n", 1'b0, 5'b01111, 32'd0, 32'h00000ABC, 1'b0, 1'b0, 6'd0);
    // Mid-operation reset takes effect before the next clock edge.
    cyc();
    issue_valid = 1'b1; issue_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd7;
    cyc();
    issue_valid = 1'b0;
    push_exp("pre_rst_b", 1'b1, 5'b01101, 32'd0, 32'hDEADBEEF, 1'b1, 1'b0, 6'd1);
    cyc();
    #1 reset = 1'b0;
    #1;
    push_exp("mid_rst_b", 1'b1, 5'b01101, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
    push_exp("mid_rst_n", 1'b0, 5'b01101, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
    cyc();
    push_exp("hold_rst_b", 1'b1, 5'b01101, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
